// File: rtl/vga_sync_receiver_pkg.sv
// vga_sync_receiver_pkg: shared 640x480@60 timing constants and receiver state encoding
// Contents:
//   VGA_* constants  - line/frame totals, sync start positions, visible sizes
//   VGA_LOCK_LINES   - good lines required before the frame check starts
//   rx_state_e       - lock qualification states of the receiver
package vga_sync_receiver_pkg;

    localparam int VGA_H_TOTAL      = 800;
    localparam int VGA_H_SYNC_START = 656;
    localparam int VGA_H_VISIBLE    = 640;
    localparam int VGA_V_TOTAL      = 525;
    localparam int VGA_V_SYNC_START = 490;
    localparam int VGA_V_VISIBLE    = 480;
    localparam int VGA_LOCK_LINES   = 4;

    typedef enum logic [1:0] {
        RX_HUNT      = 2'd0,
        RX_LINE_CHK  = 2'd1,
        RX_FRAME_CHK = 2'd2,
        RX_LOCKED    = 2'd3
    } rx_state_e;

endpackage

// File: rtl/vga_edge_sampler.sv
// vga_edge_sampler: captures syncs and colour on the pixel strobe and flags sync falling edges
// Ports:
//   clk, rst           - system clock, synchronous active-high reset
//   pix_en_i           - one-cycle pixel strobe
//   hs_i, vs_i         - active-low syncs
//   r_i, g_i, b_i      - pixel colour
//   smp_o              - high for the one clk after a sample was taken
//   hs_fall_o          - HS went 1 -> 0 between the last two samples (qualified by smp_o)
//   vs_fall_o          - VS went 1 -> 0 between the last two samples (qualified by smp_o)
//   r_o, g_o, b_o      - colour of the latest sample
module vga_edge_sampler (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en_i,
    input  logic       hs_i,
    input  logic       vs_i,
    input  logic [2:0] r_i,
    input  logic [2:0] g_i,
    input  logic [1:0] b_i,
    output logic       smp_o,
    output logic       hs_fall_o,
    output logic       vs_fall_o,
    output logic [2:0] r_o,
    output logic [2:0] g_o,
    output logic [1:0] b_o
);

    logic       smp_q;
    logic       hs_q;
    logic       hs_prev_q;
    logic       vs_q;
    logic       vs_prev_q;
    logic [2:0] r_q;
    logic [2:0] g_q;
    logic [1:0] b_q;

    // syncs reset to their idle (high) level so leaving reset never looks like a falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q     <= 1'b0;
            hs_q      <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_q      <= 1'b1;
            vs_prev_q <= 1'b1;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            smp_q <= pix_en_i;
            if (pix_en_i) begin
                hs_prev_q <= hs_q;
                hs_q      <= hs_i;
                vs_prev_q <= vs_q;
                vs_q      <= vs_i;
                r_q       <= r_i;
                g_q       <= g_i;
                b_q       <= b_i;
            end
        end
    end

    assign smp_o     = smp_q;
    assign hs_fall_o = smp_q & hs_prev_q & ~hs_q;
    assign vs_fall_o = smp_q & vs_prev_q & ~vs_q;
    assign r_o       = r_q;
    assign g_o       = g_q;
    assign b_o       = b_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers VGA raster position from HS/VS and qualifies timing lock
// Ports:
//   clk, rst             - system clock, synchronous active-high reset
//   pix_en               - one-cycle pixel strobe (1-in-4 clk)
//   HS, VS               - active-low syncs
//   R, G, B              - incoming pixel colour
//   hcount, vcount       - recovered position of the preceding sample
//   active               - recovered position lies in the visible area
//   pix_valid            - one-clk pulse per visible pixel while locked
//   pix_r, pix_g, pix_b  - captured colour, zero outside the visible area
//   frame_start          - one-clk pulse when position 0,0 is loaded
//   locked               - line and frame timing qualified
//   line_len             - last measured HS-to-HS period in samples
module vga_sync_receiver
    import vga_sync_receiver_pkg::*;
#(
    parameter int H_TOTAL      = VGA_H_TOTAL,
    parameter int H_SYNC_START = VGA_H_SYNC_START,
    parameter int V_TOTAL      = VGA_V_TOTAL,
    parameter int V_SYNC_START = VGA_V_SYNC_START,
    parameter int H_VISIBLE    = VGA_H_VISIBLE,
    parameter int V_VISIBLE    = VGA_V_VISIBLE,
    parameter int LOCK_LINES   = VGA_LOCK_LINES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        HS,
    input  logic        VS,
    input  logic [2:0]  R,
    input  logic [2:0]  G,
    input  logic [1:0]  B,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        active,
    output logic        pix_valid,
    output logic [2:0]  pix_r,
    output logic [2:0]  pix_g,
    output logic [1:0]  pix_b,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] line_len
);

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
    localparam logic [10:0] H_SYNC = 11'(H_SYNC_START);
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] H_TMO  = 11'(2 * H_TOTAL);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_TOT  = 10'(V_TOTAL);
    localparam logic [9:0]  V_SYNC = 10'(V_SYNC_START);
    localparam logic [9:0]  V_VIS  = 10'(V_VISIBLE);
    localparam logic [7:0]  LOCK_N = 8'(LOCK_LINES);

    logic       smp;
    logic       hs_fall;
    logic       vs_fall;
    logic [2:0] r_s;
    logic [2:0] g_s;
    logic [1:0] b_s;

    rx_state_e   state_q, state_d;
    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic [10:0] period_q, period_d;
    logic [10:0] line_len_q, line_len_d;
    logic [9:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  good_q, good_d;
    logic        armed_q, armed_d;
    logic        active_q, active_d;
    logic [2:0]  pix_r_q, pix_r_d;
    logic [2:0]  pix_g_q, pix_g_d;
    logic [1:0]  pix_b_q, pix_b_d;
    logic        frame_start_q, frame_start_d;
    logic        smp_d_q;
    logic        line_ok;
    logic        frame_ok;
    logic        timeout;

    vga_edge_sampler u_sampler (
        .clk       (clk),
        .rst       (rst),
        .pix_en_i  (pix_en),
        .hs_i      (HS),
        .vs_i      (VS),
        .r_i       (R),
        .g_i       (G),
        .b_i       (B),
        .smp_o     (smp),
        .hs_fall_o (hs_fall),
        .vs_fall_o (vs_fall),
        .r_o       (r_s),
        .g_o       (g_s),
        .b_o       (b_s)
    );

    // period_q counts samples since the last HS fall, so at the next fall it is the line length
    assign line_ok  = period_q == H_TOT;
    // frame_cnt_q counts HS falls since the previous VS fall, i.e. lines in the frame
    assign frame_ok = frame_cnt_q == V_TOT;
    // the period counter is about to reach (or sits saturated at) twice a line
    assign timeout  = smp & ~hs_fall & (period_q >= H_TMO - 11'd1);

    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        period_d      = period_q;
        line_len_d    = line_len_q;
        frame_cnt_d   = frame_cnt_q;
        active_d      = active_q;
        pix_r_d       = pix_r_q;
        pix_g_d       = pix_g_q;
        pix_b_d       = pix_b_q;
        frame_start_d = 1'b0;
        if (smp) begin
            hcount_d      = hs_fall ? H_SYNC : (hcount_q == H_LAST ? '0 : hcount_q + 11'd1);
            // a line wrap only counts when HS did not just re-anchor the horizontal count
            vcount_d      = vs_fall ? V_SYNC :
                            (!hs_fall && hcount_q == H_LAST) ? (vcount_q == V_LAST ? '0 : vcount_q + 10'd1) :
                            vcount_q;
            period_d      = hs_fall ? 11'd1 : (period_q == H_TMO ? period_q : period_q + 11'd1);
            line_len_d    = hs_fall ? period_q : line_len_q;
            frame_cnt_d   = vs_fall ? {9'd0, hs_fall} :
                            (hs_fall && frame_cnt_q != '1) ? frame_cnt_q + 10'd1 : frame_cnt_q;
            active_d      = hcount_d < H_VIS && vcount_d < V_VIS;
            pix_r_d       = active_d ? r_s : '0;
            pix_g_d       = active_d ? g_s : '0;
            pix_b_d       = active_d ? b_s : '0;
            frame_start_d = hcount_d == '0 && vcount_d == '0;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        armed_d = armed_q;
        if (smp) begin
            case (state_q)
                RX_HUNT: begin
                    if (hs_fall) begin
                        state_d = RX_LINE_CHK;
                        good_d  = '0;
                    end
                end
                RX_LINE_CHK: begin
                    if (hs_fall) begin
                        good_d = line_ok ? good_q + 8'd1 : '0;
                        if (line_ok && good_q + 8'd1 == LOCK_N) begin
                            state_d = RX_FRAME_CHK;
                            armed_d = 1'b0;
                        end
                    end
                end
                RX_FRAME_CHK: begin
                    // the first VS fall only opens the measurement window
                    if (vs_fall) begin
                        armed_d = 1'b1;
                        state_d = !armed_q ? RX_FRAME_CHK : (frame_ok ? RX_LOCKED : RX_HUNT);
                    end
                end
                RX_LOCKED: begin
                    if ((hs_fall && !line_ok) || (vs_fall && !frame_ok)) state_d = RX_HUNT;
                end
                default: state_d = RX_HUNT;
            endcase
            if (timeout) state_d = RX_HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RX_HUNT;
            hcount_q      <= '0;
            vcount_q      <= '0;
            period_q      <= '0;
            line_len_q    <= '0;
            frame_cnt_q   <= '0;
            good_q        <= '0;
            armed_q       <= 1'b0;
            active_q      <= 1'b0;
            pix_r_q       <= '0;
            pix_g_q       <= '0;
            pix_b_q       <= '0;
            frame_start_q <= 1'b0;
            smp_d_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            period_q      <= period_d;
            line_len_q    <= line_len_d;
            frame_cnt_q   <= frame_cnt_d;
            good_q        <= good_d;
            armed_q       <= armed_d;
            active_q      <= active_d;
            pix_r_q       <= pix_r_d;
            pix_g_q       <= pix_g_d;
            pix_b_q       <= pix_b_d;
            frame_start_q <= frame_start_d;
            smp_d_q       <= smp;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign active      = active_q;
    assign locked      = state_q == RX_LOCKED;
    // smp_d_q marks the clk in which the freshly updated position is presented
    assign pix_valid   = locked & active_q & smp_d_q;
    assign pix_r       = pix_r_q;
    assign pix_g       = pix_g_q;
    assign pix_b       = pix_b_q;
    assign frame_start = frame_start_q;
    assign line_len    = line_len_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: randomized loopback bench for vga_sync_receiver against a sample-level reference model
module tb_vga_sync_receiver;

    localparam int H = 20, HSS = 14, HSW = 3, HV = 12;
    localparam int V = 12, VSS = 9, VSW = 2, VV = 8;
    localparam int LK = 4;
    localparam int P_HUNT = 0, P_LINE = 1, P_FRAME = 2, P_LOCK = 3;

    logic        clk = 1'b0;
    logic        rst, pix_en, HS, VS;
    logic [2:0]  R, G;
    logic [1:0]  B;
    logic [10:0] hcount, line_len;
    logic [9:0]  vcount;
    logic        active, pix_valid, frame_start, locked;
    logic [2:0]  pix_r, pix_g;
    logic [1:0]  pix_b;

    int checks = 0, errors = 0;
    int n_valid, n_red, seen_lock, hit;

    // reference model: positions, sample index of last HS fall, running HS-fall totals
    int m_hs_prev, m_vs_prev, m_h, m_v, m_ref, m_n, m_len, m_tot, m_tot_vs;
    int m_ph, m_good, m_armed, m_act, m_r, m_g, m_b, m_fs;

    always #5 clk = ~clk;

    vga_sync_receiver #(
        .H_TOTAL(H), .H_SYNC_START(HSS), .V_TOTAL(V), .V_SYNC_START(VSS),
        .H_VISIBLE(HV), .V_VISIBLE(VV), .LOCK_LINES(LK)
    ) u_dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .HS(HS), .VS(VS), .R(R), .G(G), .B(B),
        .hcount(hcount), .vcount(vcount), .active(active), .pix_valid(pix_valid),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .frame_start(frame_start),
        .locked(locked), .line_len(line_len)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_hs_prev = 1; m_vs_prev = 1; m_h = 0; m_v = 0; m_ref = 0; m_n = 0; m_len = 0;
        m_tot = 0; m_tot_vs = 0; m_ph = P_HUNT; m_good = 0; m_armed = 0;
        m_act = 0; m_r = 0; m_g = 0; m_b = 0; m_fs = 0;
    endfunction

    function automatic void model_step(input logic hs, input logic vs, input int r, input int g, input int b);
        int per, nh, nv;
        bit hf, vf, ok_line, ok_frame, tmo;
        hf = m_hs_prev == 1 && hs == 1'b0;
        vf = m_vs_prev == 1 && vs == 1'b0;
        per = (m_n - m_ref < 2 * H) ? m_n - m_ref : 2 * H;
        ok_line = per == H;
        ok_frame = (m_tot - m_tot_vs) == V;
        tmo = !hf && (m_n - m_ref + 1 >= 2 * H);
        nh = hf ? HSS : (m_h + 1) % H;
        nv = vf ? VSS : ((!hf && m_h == H - 1) ? (m_v + 1) % V : m_v);
        if (hf) m_len = per;
        if (m_ph == P_HUNT && hf) begin
            m_ph = P_LINE;
            m_good = 0;
        end else if (m_ph == P_LINE && hf) begin
            m_good = ok_line ? m_good + 1 : 0;
            if (m_good == LK) begin
                m_ph = P_FRAME;
                m_armed = 0;
            end
        end else if (m_ph == P_FRAME && vf) begin
            if (m_armed != 0) m_ph = ok_frame ? P_LOCK : P_HUNT;
            m_armed = 1;
        end else if (m_ph == P_LOCK && ((hf && !ok_line) || (vf && !ok_frame))) begin
            m_ph = P_HUNT;
        end
        if (tmo) m_ph = P_HUNT;
        if (hf) m_ref = m_n;
        if (vf) m_tot_vs = m_tot;
        if (hf) m_tot++;
        m_h = nh;
        m_v = nv;
        m_act = (nh < HV && nv < VV) ? 1 : 0;
        m_r = m_act ? r : 0;
        m_g = m_act ? g : 0;
        m_b = m_act ? b : 0;
        m_fs = (nh == 0 && nv == 0) ? 1 : 0;
        m_hs_prev = hs;
        m_vs_prev = vs;
        m_n++;
    endfunction

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_hcount"}, int'(hcount), 0);
        chk({pfx, "_vcount"}, int'(vcount), 0);
        chk({pfx, "_active"}, int'(active), 0);
        chk({pfx, "_pix_valid"}, int'(pix_valid), 0);
        chk({pfx, "_pix_rgb"}, int'({pix_r, pix_g, pix_b}), 0);
        chk({pfx, "_frame_start"}, int'(frame_start), 0);
        chk({pfx, "_locked"}, int'(locked), 0);
        chk({pfx, "_line_len"}, int'(line_len), 0);
    endtask

    task automatic do_reset(input string pfx);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_all_zero(pfx);
        model_reset();
    endtask

    // one pixel period: strobe, sampler edge, receiver update edge, two idle clks
    task automatic pixel(input logic hs, input logic vs, input logic [2:0] r, input logic [2:0] g, input logic [1:0] b);
        HS = hs; VS = vs; R = r; G = g; B = b; pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        chk("hcount_latency", int'(hcount), m_h);
        chk("locked_latency", int'(locked), int'(m_ph == P_LOCK));
        @(posedge clk); #1;
        model_step(hs, vs, int'(r), int'(g), int'(b));
        chk("hcount", int'(hcount), m_h);
        chk("vcount", int'(vcount), m_v);
        chk("active", int'(active), m_act);
        chk("pix_r", int'(pix_r), m_r);
        chk("pix_g", int'(pix_g), m_g);
        chk("pix_b", int'(pix_b), m_b);
        chk("frame_start", int'(frame_start), m_fs);
        chk("locked", int'(locked), int'(m_ph == P_LOCK));
        chk("line_len", int'(line_len), m_len);
        chk("pix_valid", int'(pix_valid), int'(m_ph == P_LOCK && m_act != 0));
        if (pix_valid) begin
            n_valid++;
            if (pix_r == 3'd7) n_red++;
        end
        if (locked) seen_lock = 1;
        @(posedge clk); #1;
        chk("pix_valid_width", int'(pix_valid), 0);
        chk("frame_start_width", int'(frame_start), 0);
        @(posedge clk); #1;
    endtask

    // one generator frame; short_row drops the last pixel of that line, skip_row drops a whole line
    task automatic frame(input int short_row, input int skip_row, input bit solid, input bit noise, input int rst_at);
        for (int v = 0; v < V; v++) begin
            if (v == skip_row) continue;
            for (int h = 0; h < H; h++) begin
                logic hs, vs;
                logic [2:0] r, g;
                logic [1:0] b;
                if (v == short_row && h == H - 1) continue;
                if (v * H + h == rst_at) do_reset("mid_reset");
                hs = !(h >= HSS && h < HSS + HSW);
                vs = !(v >= VSS && v < VSS + VSW);
                if (noise && $urandom_range(47) == 0) hs = ~hs;
                if (noise && $urandom_range(95) == 0) vs = ~vs;
                r = solid ? 3'd7 : 3'($urandom);
                g = solid ? 3'd0 : 3'($urandom);
                b = solid ? 2'd0 : 2'($urandom);
                pixel(hs, vs, r, g, b);
            end
        end
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; HS = 1'b1; VS = 1'b1; R = '0; G = '0; B = '0;
        n_valid = 0; n_red = 0; seen_lock = 0; hit = 0;
        model_reset();
        do_reset("reset");
        repeat (4) frame(-1, -1, 0, 0, -1);
        chk("initial_lock", int'(locked), 1);
        chk("initial_line_len", int'(line_len), H);
        n_valid = 0; n_red = 0;
        frame(-1, -1, 1, 0, -1);
        chk("solid_valid_count", n_valid, HV * VV);
        chk("solid_red_count", n_red, HV * VV);
        frame(3, -1, 0, 0, -1);
        chk("short_line_unlock", int'(locked), 0);
        repeat (4) frame(-1, -1, 0, 0, -1);
        chk("short_line_relock", int'(locked), 1);
        for (int i = 0; i < 2 * H + 5; i++) pixel(1'b1, 1'b1, 3'($urandom), 3'($urandom), 2'($urandom));
        chk("timeout_unlock", int'(locked), 0);
        chk("timeout_line_len_held", int'(line_len), H);
        seen_lock = 0;
        for (int f = 0; f < 5; f++) begin
            if (m_ph == P_FRAME && m_armed != 0) begin
                hit = 1;
                frame(-1, 2, 0, 0, -1);
                break;
            end
            frame(-1, -1, 0, 0, -1);
        end
        chk("short_frame_reached", hit, 1);
        chk("short_frame_unlock", int'(locked), 0);
        chk("short_frame_no_lock_pulse", seen_lock, 0);
        repeat (4) frame(-1, -1, 0, 0, -1);
        chk("short_frame_relock", int'(locked), 1);
        frame(-1, -1, 0, 0, 5 * H + 7);
        repeat (4) frame(-1, -1, 0, 0, -1);
        chk("reset_relock", int'(locked), 1);
        repeat (3) frame(-1, -1, 0, 1, -1);
        repeat (4) frame(-1, -1, 0, 0, -1);
        chk("final_lock", int'(locked), 1);
        chk("final_line_len", int'(line_len), H);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
